ahb_wait_slave: RTL and testbench
=================================

# ahb_wait_slave

AHB slave responder that answers the masters on the shared `amba_ahb_m3s3` fabric. It holds a small word-organised register memory and inserts a parameterised number of wait states per transfer. Misaligned or oversize accesses get the two-cycle ERROR response. It is the target-side counterpart to the `ahb_master`/`ahb_test` initiators and lets benches exercise HREADY stalls and HRESP=ERROR handling in one place.

## Interface
Parameters:
- ADD_WIDTH, 6: log2 of memory depth in 32-bit words; uses HADDR[ADD_WIDTH+1:2].
- DELAY, 2: wait states inserted per NONSEQ/SEQ transfer (0..15).

Ports:
- HCLK  in  1  bus clock; all logic on rising edge.
- HRESET  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high).
- HSEL  in  1  slave select from fabric decoder.
- HADDR  in  32  address.
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWRITE  in  1  1=write.
- HSIZE  in  3  0=byte, 1=half, 2=word; >2 is an error.
- HBURST  in  3  ignored (each beat handled independently).
- HWDATA  in  32  write data, valid throughout the data phase.
- HREADYin  in  1  fabric-wide HREADY.
- HRDATA  out  32  read data.
- HRESP  out  2  OKAY=0, ERROR=1.
- HREADYout  out  1  data-phase completion.

## Operation
- Address phase accepted when HSEL & HREADYin & HTRANS[1]=1. On accept, register address, size, write flag and an error flag.
- Error flag conditions:
  - HSIZE>2;
  - HSIZE=1 with HADDR[0]=1;
  - HSIZE=2 with HADDR[1:0]≠0.
- HSEL & HREADYin with IDLE/BUSY, or HSEL=0: no data phase, OKAY, zero wait.
- FSM states:
  - IDLE: HREADYout=1, HRESP=OKAY.
  - WAIT: counts down DELAY cycles.
  - ERR1: HREADYout=0, HRESP=ERROR.
  - ERR2: HREADYout=1, HRESP=ERROR.
- Transitions:
  - IDLE→ERR1 on accept with error flag (DELAY is skipped for errors).
  - IDLE→WAIT on accept with DELAY>0.
  - IDLE stays on accept with DELAY=0.
  - WAIT→IDLE after DELAY cycles of HREADYout=0.
  - ERR1→ERR2→IDLE. A new accept is allowed in ERR2 and on the completing cycle of WAIT, so the next data phase starts immediately.
- Write:
  - Memory is updated at the edge ending the data phase (HREADYout=1).
  - Only byte lanes selected by size/HADDR[1:0] are written, little-endian. Byte n uses HWDATA[8n+7:8n]; half at addr[1]=h uses lanes 2h,2h+1.
  - Errored writes never modify memory.
- Read:
  - HRDATA presents the full 32-bit word at the final data-phase cycle. Lane masking is the master's job.
  - HRDATA is 0 for errored reads and for cycles where no read is completing.
- Forwarding: if a read's address phase coincides with the completing data phase of a write to the same word, the read returns the merged (newly written) data.

## Timing
- Reset values: HREADYout=1, HRESP=0, HRDATA=0, FSM=IDLE, memory all zero. Memory clear may take at most 2**ADD_WIDTH cycles; during the clear, HREADYout=0 on any accepted transfer.
- Latency:
  - DELAY=0: data phase is 1 cycle.
  - Otherwise: DELAY+1 cycles, with HREADYout=0 for exactly DELAY cycles.
  - Error: exactly 2 cycles.
- HRESP=ERROR only in ERR1/ERR2. HRESP=OKAY in all other states, including wait states.
- HREADYin=0 in IDLE: no accept, regardless of HTRANS.
- HRESET asserted mid-WAIT/ERR: next cycle FSM=IDLE, HREADYout=1, HRESP=0. An in-flight write is discarded.
- Back-to-back SEQ beats with DELAY=0: one beat completes per cycle.

## Test plan
- Reset: hold HRESET 3 cycles → HREADYout=1, HRESP=0, HRDATA=0; a word read at 0x2000_0000 returns 0x0000_0000.
- DELAY=2: word write 0xDEADBEEF to 0x2000_0004, then word read → each data phase shows HREADYout low exactly 2 cycles; read returns 0xDEADBEEF.
- Byte write HSIZE=0, addr 0x2000_0005, HWDATA=0x0000AB00, then word read of 0x2000_0004 → 0xDEADABEF.
- DELAY=0: NONSEQ write 0x1234_5678 to 0x2000_0010 immediately followed by a read of 0x2000_0010 → read returns 0x1234_5678 with no stall (forwarding).
- Halfword write at 0x2000_0001 → cycle 1: HREADYout=0, HRESP=1; cycle 2: HREADYout=1, HRESP=1; memory word unchanged.
- Two cases:
  - HTRANS=BUSY with HSEL=1 → OKAY, no stall.
  - HRESET pulsed during the second wait cycle of a DELAY=3 write → next cycle HREADYout=1, HRESP=0; target word is still 0.

Source files
------------

// File: rtl/ahb_wait_slave_if.sv
// AHB slave-side bus bundle for ahb_wait_slave: address/control, write data
// and the HREADY/HRESP/HRDATA response.
interface ahb_wait_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADYin;
  logic [31:0] HRDATA;
  logic [1:0]  HRESP;
  logic        HREADYout;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADYin,
    input  HRDATA, HRESP, HREADYout
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADYin,
    output HRDATA, HRESP, HREADYout
  );
endinterface

// File: rtl/ahb_wait_slave.sv
// AHB slave with a word-organised register memory, DELAY wait states per
// transfer and a two-cycle ERROR response for misaligned/oversize accesses.
module ahb_wait_slave #(
  parameter int ADD_WIDTH = 6,
  parameter int DELAY     = 2
) (
  input logic             HCLK,
  input logic             HRESET,
  ahb_wait_slave_if.slave bus
);
  localparam int         DEPTH    = 1 << ADD_WIDTH;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_ERR1  = 2'd2;
  localparam logic [1:0] ST_ERR2  = 2'd3;
  localparam logic [3:0] CNT_LOAD = (DELAY > 0) ? 4'(DELAY - 1) : 4'd0;

  logic [1:0]           state;
  logic [3:0]           cnt;
  logic                 vld_p0;
  logic [ADD_WIDTH-1:0] widx_p0;
  logic [1:0]           boff_p0;
  logic [2:0]           size_p0;
  logic                 write_p0;
  logic [31:0]          mem [DEPTH];
  logic [DEPTH-1:0]     wvalid;

  logic        hready;
  logic        accept;
  logic        addr_err;
  logic        done;
  logic        wr_en;
  logic [31:0] cur_word;
  logic [31:0] merged;
  logic        unused_bits;

  function automatic logic size_err(input logic [2:0] sz, input logic [1:0] a);
    return (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a != 2'b00);
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] sz, input logic [1:0] a);
    case (sz)
      3'd0:    return 4'b0001 << a;
      3'd1:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return r;
  endfunction

  assign hready   = (state == ST_IDLE) || (state == ST_ERR2);
  assign accept   = bus.HSEL && bus.HREADYin && bus.HTRANS[1] && hready;
  assign addr_err = size_err(bus.HSIZE, bus.HADDR[1:0]);
  assign done     = (state == ST_IDLE) && vld_p0;
  assign wr_en    = done && write_p0 && !HRESET;

  // Unwritten words read as zero, so reset only has to clear the valid bits.
  // A read issued alongside a completing write sees the merged word because
  // its data phase starts after that write's commit edge.
  assign cur_word = wvalid[widx_p0] ? mem[widx_p0] : 32'd0;
  assign merged   = merge_lanes(cur_word, bus.HWDATA, lane_mask(size_p0, boff_p0));

  assign bus.HREADYout = hready;
  assign bus.HRESP     = (state == ST_ERR1 || state == ST_ERR2) ? 2'd1 : 2'd0;
  assign bus.HRDATA    = (done && !write_p0) ? cur_word : 32'd0;

  assign unused_bits = ^{bus.HBURST, bus.HADDR[31:ADD_WIDTH+2], bus.HTRANS[0]};

  // Address phase -> data phase (p0)
  always_ff @(posedge HCLK) begin
    if (accept) begin
      widx_p0  <= bus.HADDR[ADD_WIDTH+1:2];
      boff_p0  <= bus.HADDR[1:0];
      size_p0  <= bus.HSIZE;
      write_p0 <= bus.HWRITE;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state  <= ST_IDLE;
      cnt    <= 4'd0;
      vld_p0 <= 1'b0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (cnt == 4'd0) state <= ST_IDLE;
          else             cnt   <= cnt - 4'd1;
        end
        ST_ERR1: state <= ST_ERR2;
        default: begin
          if (accept) begin
            vld_p0 <= !addr_err;
            if (addr_err) begin
              state <= ST_ERR1;
            end else if (DELAY > 0) begin
              state <= ST_WAIT;
              cnt   <= CNT_LOAD;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            vld_p0 <= 1'b0;
            state  <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Data phase completion -> memory commit
  always_ff @(posedge HCLK) begin
    if (HRESET)     wvalid <= '0;
    else if (wr_en) wvalid[widx_p0] <= 1'b1;
  end

  always_ff @(posedge HCLK) begin
    if (wr_en) mem[widx_p0] <= merged;
  end
endmodule

// File: tb/tb_ahb_wait_slave.sv
// Bench for ahb_wait_slave: three instances (DELAY 2/0/3), a transaction-level
// expectation queue checked every cycle, and directed literal checks.
module tb_ahb_wait_slave;
  logic HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  logic        HRESET;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hrdy_low;
  int          active;
  bit          chk_en;

  logic [31:0] rdata;
  logic [1:0]  resp;
  logic        rdy;

  int n_checks = 0;
  int n_fail   = 0;
  int dly [3] = '{2, 0, 3};

  ahb_wait_slave_if bus0 ();
  ahb_wait_slave_if bus1 ();
  ahb_wait_slave_if bus2 ();

  ahb_wait_slave #(.ADD_WIDTH(6), .DELAY(2)) dut0 (.HCLK(HCLK), .HRESET(HRESET), .bus(bus0.slave));
  ahb_wait_slave #(.ADD_WIDTH(6), .DELAY(0)) dut1 (.HCLK(HCLK), .HRESET(HRESET), .bus(bus1.slave));
  ahb_wait_slave #(.ADD_WIDTH(6), .DELAY(3)) dut2 (.HCLK(HCLK), .HRESET(HRESET), .bus(bus2.slave));

  assign bus0.HSEL = hsel && (active == 0);
  assign bus1.HSEL = hsel && (active == 1);
  assign bus2.HSEL = hsel && (active == 2);
  assign bus0.HADDR = haddr;   assign bus1.HADDR = haddr;   assign bus2.HADDR = haddr;
  assign bus0.HTRANS = htrans; assign bus1.HTRANS = htrans; assign bus2.HTRANS = htrans;
  assign bus0.HWRITE = hwrite; assign bus1.HWRITE = hwrite; assign bus2.HWRITE = hwrite;
  assign bus0.HSIZE = hsize;   assign bus1.HSIZE = hsize;   assign bus2.HSIZE = hsize;
  assign bus0.HBURST = 3'd0;   assign bus1.HBURST = 3'd0;   assign bus2.HBURST = 3'd0;
  assign bus0.HWDATA = hwdata; assign bus1.HWDATA = hwdata; assign bus2.HWDATA = hwdata;
  assign bus0.HREADYin = bus0.HREADYout && !hrdy_low;
  assign bus1.HREADYin = bus1.HREADYout && !hrdy_low;
  assign bus2.HREADYin = bus2.HREADYout && !hrdy_low;

  always_comb begin
    rdata = bus0.HRDATA; resp = bus0.HRESP; rdy = bus0.HREADYout;
    if (active == 1) begin rdata = bus1.HRDATA; resp = bus1.HRESP; rdy = bus1.HREADYout; end
    if (active == 2) begin rdata = bus2.HRDATA; resp = bus2.HRESP; rdy = bus2.HREADYout; end
  end

  typedef struct {
    logic        rdy;
    logic [1:0]  resp;
    bit          fin;
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mm [3][64];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++)
      for (int w = 0; w < 64; w++) mm[d][w] = 32'd0;
  endtask

  task automatic model_write(input int d, input logic [31:0] a, input logic [2:0] sz,
                             input logic [31:0] wd);
    int n, lo;
    n  = 1 << sz;
    lo = int'(a[1:0]) & ~(n - 1);
    for (int b = 0; b < 4; b++)
      if (b >= lo && b < lo + n) mm[d][a[7:2]][8*b +: 8] = wd[8*b +: 8];
  endtask

  // Every cycle: the output the current data phase must show, or idle/OKAY.
  always @(negedge HCLK) begin
    exp_t        e;
    logic [31:0] er;
    if (chk_en) begin
      e = '{rdy: 1'b1, resp: 2'd0, fin: 1'b0, wr: 1'b0, addr: 32'd0, size: 3'd0, wdata: 32'd0};
      if (q.size() > 0) e = q.pop_front();
      er = 32'd0;
      if (e.fin && !e.wr) er = mm[active][e.addr[7:2]];
      if (e.fin && e.wr)  model_write(active, e.addr, e.size, e.wdata);
      chk("cyc_hready", 32'(rdy), 32'(e.rdy));
      chk("cyc_hresp", 32'(resp), 32'(e.resp));
      chk("cyc_hrdata", rdata, er);
    end
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic xfer(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, input logic [1:0] tr);
    int   guard;
    bit   acc;
    bit   err;
    exp_t e;
    hsel = 1'b1; haddr = a; hwrite = wr; hsize = sz; htrans = tr;
    guard = 0; acc = 1'b0;
    while (!acc && guard < 50) begin
      acc = rdy && !hrdy_low;
      tick();
      guard++;
    end
    if (!acc) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      err = (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00);
      e = '{rdy: 1'b0, resp: 2'd0, fin: 1'b0, wr: wr, addr: a, size: sz, wdata: wd};
      if (err) begin
        e.resp = 2'd1; q.push_back(e);
        e.rdy = 1'b1;  q.push_back(e);
      end else begin
        repeat (dly[active]) q.push_back(e);
        e.rdy = 1'b1; e.fin = 1'b1; q.push_back(e);
      end
    end
    hwdata = wd;
    htrans = 2'd0;
  endtask

  task automatic watch(input string nm, input int exp_stalls, input logic [1:0] exp_resp,
                       input logic [31:0] exp_rdata);
    int stalls;
    htrans = 2'd0;
    stalls = 0;
    @(negedge HCLK);
    while (!rdy && stalls < 40) begin
      stalls++;
      @(negedge HCLK);
    end
    chk({nm, "_stalls"}, 32'(stalls), 32'(exp_stalls));
    chk({nm, "_hresp"}, 32'(resp), 32'(exp_resp));
    chk({nm, "_hrdata"}, rdata, exp_rdata);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESET = 1'b1; hsel = 1'b0; htrans = 2'd0; haddr = 32'd0; hwrite = 1'b0;
    hsize = 3'd2; hwdata = 32'd0; hrdy_low = 1'b0; active = 0; chk_en = 1'b0;
    model_reset();

    tick();
    chk_en = 1'b1;
    tick(); tick();
    HRESET = 1'b0;
    @(negedge HCLK);
    chk("rst_hready", 32'(rdy), 32'd1);
    chk("rst_hresp", 32'(resp), 32'd0);
    chk("rst_hrdata", rdata, 32'd0);
    chk("rst_hready_d0", 32'(bus1.HREADYout), 32'd1);
    tick();

    // DELAY=2 instance
    xfer(1'b0, 32'h2000_0000, 3'd2, 32'd0, 2'd2);
    watch("rst_read", 2, 2'd0, 32'h0000_0000);
    xfer(1'b1, 32'h2000_0004, 3'd2, 32'hDEAD_BEEF, 2'd2);
    watch("w_word", 2, 2'd0, 32'd0);
    xfer(1'b0, 32'h2000_0004, 3'd2, 32'd0, 2'd2);
    watch("r_word", 2, 2'd0, 32'hDEAD_BEEF);
    xfer(1'b1, 32'h2000_0005, 3'd0, 32'h0000_AB00, 2'd2);
    watch("w_byte", 2, 2'd0, 32'd0);
    xfer(1'b0, 32'h2000_0004, 3'd2, 32'd0, 2'd2);
    watch("r_byte", 2, 2'd0, 32'hDEAD_ABEF);
    xfer(1'b1, 32'h2000_0006, 3'd1, 32'h5A5A_0000, 2'd2);
    xfer(1'b0, 32'h2000_0004, 3'd2, 32'd0, 2'd2);
    watch("r_half", 2, 2'd0, 32'h5A5A_ABEF);

    xfer(1'b1, 32'h2000_0001, 3'd1, 32'hFFFF_FFFF, 2'd2);
    watch("err_half", 1, 2'd1, 32'd0);
    xfer(1'b0, 32'h2000_0000, 3'd2, 32'd0, 2'd2);
    watch("err_half_mem", 2, 2'd0, 32'd0);
    xfer(1'b1, 32'h2000_0006, 3'd2, 32'h1111_1111, 2'd2);
    xfer(1'b0, 32'h2000_0008, 3'd3, 32'd0, 2'd2);
    watch("err_size3", 1, 2'd1, 32'd0);
    xfer(1'b0, 32'h2000_0004, 3'd2, 32'd0, 2'd2);
    watch("err_word_mem", 2, 2'd0, 32'h5A5A_ABEF);

    hsel = 1'b1; htrans = 2'd1; haddr = 32'h2000_0004;
    @(negedge HCLK);
    tick();
    @(negedge HCLK);
    chk("busy_hready", 32'(rdy), 32'd1);
    chk("busy_hresp", 32'(resp), 32'd0);
    tick();
    htrans = 2'd2; hrdy_low = 1'b1;
    tick(); tick();
    htrans = 2'd0; hrdy_low = 1'b0;
    @(negedge HCLK);
    chk("hreadyin_low_hready", 32'(rdy), 32'd1);
    tick();
    hsel = 1'b0; htrans = 2'd2;
    tick(); tick();
    htrans = 2'd0;
    @(negedge HCLK);
    chk("hsel_low_hready", 32'(rdy), 32'd1);
    tick();

    // DELAY=0 instance
    active = 1;
    tick();
    xfer(1'b1, 32'h2000_0010, 3'd2, 32'h1234_5678, 2'd2);
    xfer(1'b0, 32'h2000_0010, 3'd2, 32'd0, 2'd2);
    watch("fwd", 0, 2'd0, 32'h1234_5678);
    xfer(1'b1, 32'h2000_0020, 3'd2, 32'h1111_1111, 2'd2);
    xfer(1'b1, 32'h2000_0024, 3'd2, 32'h2222_2222, 2'd3);
    xfer(1'b1, 32'h2000_0028, 3'd2, 32'h3333_3333, 2'd3);
    xfer(1'b0, 32'h2000_0020, 3'd2, 32'd0, 2'd3);
    xfer(1'b0, 32'h2000_0024, 3'd2, 32'd0, 2'd3);
    xfer(1'b0, 32'h2000_0028, 3'd2, 32'd0, 2'd3);
    watch("seq_last", 0, 2'd0, 32'h3333_3333);
    xfer(1'b1, 32'h2000_0012, 3'd2, 32'hFFFF_FFFF, 2'd2);
    watch("err_d0", 1, 2'd1, 32'd0);

    // DELAY=3 instance
    active = 2;
    tick();
    xfer(1'b1, 32'h2000_0034, 3'd2, 32'hA5A5_A5A5, 2'd2);
    xfer(1'b0, 32'h2000_0034, 3'd2, 32'd0, 2'd2);
    watch("d3_read", 3, 2'd0, 32'hA5A5_A5A5);
    xfer(1'b1, 32'h2000_0030, 3'd2, 32'hCAFE_F00D, 2'd2);
    tick();
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    q.delete();
    model_reset();
    @(negedge HCLK);
    chk("rst_mid_hready", 32'(rdy), 32'd1);
    chk("rst_mid_hresp", 32'(resp), 32'd0);
    tick();
    xfer(1'b0, 32'h2000_0030, 3'd2, 32'd0, 2'd2);
    watch("rst_mid_mem", 3, 2'd0, 32'd0);

    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
